// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S frame transmitter: default widths,
// the stereo frame record and the word-select placement rule.
package i2s_pkg;

  localparam int SAMPLE_W = 24;
  localparam int SLOT_W   = 32;

  // Word-select changes this many bit clocks ahead of the slot MSB.
  localparam int LR_LEAD  = 1;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } frame_t;

  function automatic logic lr_for_bitpos(input int unsigned bitpos,
                                         input int unsigned slot_w);
    return (bitpos >= slot_w - LR_LEAD) && (bitpos <= 2 * slot_w - 1 - LR_LEAD);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous frame FIFO with first-word-fall-through head and occupancy
// outputs, both the current count and the value it takes on the next edge.
module sample_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_valid,
  input  frame_t        push_data,
  output logic          push_ready,
  input  logic          pop,
  output frame_t        head,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign push_ready = !rst && (count != FULL);
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop && (count != '0) && !rst;
  assign head       = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_frame_tx.sv
// Buffers stereo PCM frames and serialises them as an I2S stream with the
// bit clock, word select and data all derived from the system clock.
module i2s_frame_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = i2s_pkg::SAMPLE_W,
  parameter int SLOT_W    = i2s_pkg::SLOT_W,
  parameter int BCLK_DIV  = 4,
  parameter int DEPTH     = 4,
  parameter int LOW_WATER = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] s_left,
  input  logic [SAMPLE_W-1:0] s_right,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                req,
  output logic                underrun
);

  localparam int AW    = $clog2(DEPTH);
  localparam int DIV_W = $clog2(BCLK_DIV);
  localparam int BP_W  = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BP_W-1:0]  BP_LAST  = BP_W'(2 * SLOT_W - 1);
  localparam logic [BP_W-1:0]  BP_SLOT  = BP_W'(SLOT_W);
  localparam logic [AW:0]      LOW_LVL  = (AW + 1)'(LOW_WATER);

  frame_t              push_data;
  frame_t              fifo_head;
  logic [AW:0]         fifo_count;
  logic [AW:0]         fifo_count_next;
  logic                fifo_empty;

  logic [DIV_W-1:0]    div;
  logic [BP_W-1:0]     bitpos;
  logic [BP_W-1:0]     bitpos_next;
  logic [BP_W-1:0]     slot_k;
  logic                fall_evt;
  logic                frame_start;
  frame_t              frame_q;
  frame_t              frame_next;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] sample_shift;
  logic                sdata_next;
  logic                lr_next;

  assign push_data  = '{left: s_left, right: s_right};
  assign fifo_empty = (fifo_count == '0);

  sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (s_valid),
    .push_data  (push_data),
    .push_ready (s_ready),
    .pop        (frame_start),
    .head       (fifo_head),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  // Everything below only moves on the bclk falling event; entering bitpos 0
  // swaps in a new frame (or silence when the FIFO ran dry).
  always_comb begin
    fall_evt     = enable && (div == DIV_LAST);
    bitpos_next  = (bitpos == BP_LAST) ? '0 : bitpos + 1'b1;
    frame_start  = fall_evt && (bitpos_next == '0);
    frame_next   = frame_q;
    if (frame_start) frame_next = fifo_empty ? '0 : fifo_head;

    sample = frame_next.left;
    slot_k = bitpos_next;
    if (bitpos_next >= BP_SLOT) begin
      sample = frame_next.right;
      slot_k = bitpos_next - BP_SLOT;
    end

    // Shifting past the sample width leaves zeros, which gives the slot padding.
    sample_shift = sample << slot_k;
    sdata_next   = sample_shift[SAMPLE_W-1];
    lr_next      = lr_for_bitpos(int'(bitpos_next), SLOT_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      bitpos   <= BP_LAST;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      req      <= 1'b1;
      frame_q  <= '0;
    end else if (!enable) begin
      div      <= '0;
      bitpos   <= BP_LAST;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      req      <= (fifo_count_next <= LOW_LVL);
    end else begin
      div      <= fall_evt ? '0 : div + 1'b1;
      underrun <= frame_start && fifo_empty;
      req      <= (fifo_count_next <= LOW_LVL);
      if (div == DIV_HALF) bclk <= 1'b1;
      if (fall_evt) begin
        bclk    <= 1'b0;
        bitpos  <= bitpos_next;
        lrclk   <= lr_next;
        sdata   <= sdata_next;
        frame_q <= frame_next;
      end
    end
  end

endmodule
